alu_serial_seq: RTL

ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

---
 rtl/alu_serial_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial ALU sequencer. It captures two WIDTH-bit operands
//               and an op code, then walks an external combinational 1-bit
//               ALU slice from LSB to MSB, one bit per clock. It collects the
//               result bits and the ripple carry, and produces the
//               Zero/CarryOut/Overflow/Invalid status flags.
// Ports       : clk, reset (async, active-high)
//               start, ALUop_in[3:0], A, B     - request and operands
//               slice_a/b/cin/op -> slice      - drive to external 1-bit ALU
//               slice_result/cout <- slice     - slice response
//               busy, done                     - sequencing status
//               Result, Zero, CarryOut, Overflow, Invalid - held outcome
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUop_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [3:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Invalid
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WIDTH - 1);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;

    logic w_legal_in;
    logic w_is_arith;
    logic w_is_slt;
    logic w_ovf_msb;

    assign w_legal_in = (ALUop_in == c_OP_AND) || (ALUop_in == c_OP_OR)  ||
                        (ALUop_in == c_OP_ADD) || (ALUop_in == c_OP_SUB) ||
                        (ALUop_in == c_OP_NOR) || (ALUop_in == c_OP_SLT);
    assign w_is_arith = (op_q == c_OP_ADD) || (op_q == c_OP_SUB);
    assign w_is_slt   = (op_q == c_OP_SLT);

    // While the MSB is being processed, carry_q holds the carry into the MSB
    // and slice_cout is the final carry out, so overflow can be formed
    // without keeping a separate copy of the MSB carry-in.
    assign w_ovf_msb  = carry_q ^ slice_cout;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        inv_d    = inv_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    op_d     = ALUop_in;
                    idx_d    = '0;
                    // Binvert doubles as the carry-in: it supplies the +1
                    // of the two's-complement subtraction.
                    carry_d  = ALUop_in[2];
                    result_d = '0;
                    zero_d   = 1'b0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    inv_d    = 1'b0;
                    if (w_legal_in) begin
                        state_d = S_RUN;
                    end else begin
                        // Unsupported op: the all-zero result is already
                        // known, so Zero is set together with Invalid.
                        state_d = S_FINISH;
                        inv_d   = 1'b1;
                        zero_d  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                result_d[idx_q] = slice_result;
                carry_d         = slice_cout;
                idx_d           = idx_q + IDX_W'(1);
                if (idx_q == c_IDX_LAST) begin
                    state_d = S_FINISH;
                    idx_d   = '0;
                    if (w_is_arith) begin
                        cout_d = slice_cout;
                        ovf_d  = w_ovf_msb;
                    end else if (w_is_slt) begin
                        // Signed less-than: sign of the difference,
                        // corrected when the subtraction overflowed.
                        result_d    = '0;
                        result_d[0] = slice_result ^ w_ovf_msb;
                    end
                    zero_d = ~|result_d;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice drive: quiet outside RUN
    // ------------------------------------------------------------------
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 4'b0000;
        if (state_q == S_RUN) begin
            slice_a   = a_q[idx_q];
            slice_b   = b_q[idx_q];
            slice_cin = carry_q;
            // SLT runs as a subtraction in the slice; the compare is
            // resolved once the MSB has been processed.
            slice_op  = w_is_slt ? c_OP_SUB : op_q;
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_FINISH);
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;
    assign Invalid  = inv_q;

endmodule
`default_nettype wire
